// File: rtl/vgachargen_mem_arb.sv
// vgachargen_mem_arb: arbitrates port A of the character-generator memories
// (ch_map, col_map, ch_t_rw) between a host request channel and an optional
// screen-fill engine.
//
// Host channel : host_valid_i/host_ready_o handshake, we/sel/addr/wdata in,
//                rsp_valid_o/rsp_err_o/rsp_rdata_o one cycle after acceptance.
// Fill engine  : fill_start_i latches fill_char_i/fill_col_i and writes every
//                cell of ch_map and col_map together; fill_busy_o, fill_done_o.
// Memory port A: *_addr_o/*_data_o/*_wen_o per memory, *_rdata_i returned
//                with one cycle of latency.
//
// Build option : define VGACHARGEN_MEM_ARB_FILL_EN to include the fill FSM and
//                the round-robin arbiter; otherwise the host always owns port A.
module vgachargen_mem_arb #(
  parameter int unsigned CELLS     = 2400,
  parameter int unsigned CH_MAP_DW = 9,
  parameter int unsigned COL_DW    = 8,
  parameter int unsigned CH_T_AW   = 8,
  parameter int unsigned CH_T_DW   = 128
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  // host request/response
  input  logic                 host_valid_i,
  output logic                 host_ready_o,
  input  logic                 host_we_i,
  input  logic [1:0]           host_sel_i,
  input  logic [11:0]          host_addr_i,
  input  logic [CH_T_DW-1:0]   host_wdata_i,
  output logic                 rsp_valid_o,
  output logic                 rsp_err_o,
  output logic [CH_T_DW-1:0]   rsp_rdata_o,
  // screen fill
  input  logic                 fill_start_i,
  input  logic [CH_MAP_DW-1:0] fill_char_i,
  input  logic [COL_DW-1:0]    fill_col_i,
  output logic                 fill_busy_o,
  output logic                 fill_done_o,
  // memory port A
  output logic [11:0]          ch_map_addr_o,
  output logic [CH_MAP_DW-1:0] ch_map_data_o,
  output logic                 ch_map_wen_o,
  input  logic [CH_MAP_DW-1:0] ch_map_rdata_i,
  output logic [11:0]          col_map_addr_o,
  output logic [COL_DW-1:0]    col_map_data_o,
  output logic                 col_map_wen_o,
  input  logic [COL_DW-1:0]    col_map_rdata_i,
  output logic [CH_T_AW-1:0]   ch_t_rw_addr_o,
  output logic [CH_T_DW-1:0]   ch_t_rw_data_o,
  output logic                 ch_t_rw_wen_o,
  input  logic [CH_T_DW-1:0]   ch_t_rw_rdata_i
);

  localparam logic [1:0] SelChMap  = 2'd0;
  localparam logic [1:0] SelColMap = 2'd1;
  localparam logic [1:0] SelChT    = 2'd2;
  localparam logic [1:0] SelRsvd   = 2'd3;

  logic                 host_gnt;
  logic                 fill_gnt;
  logic                 host_err;
  logic [11:0]          fill_cnt;
  logic [CH_MAP_DW-1:0] fill_char;
  logic [COL_DW-1:0]    fill_col;

  // Reserved target, or a map access beyond the last cell.
  always_comb begin
    host_err = 1'b0;
    if (host_sel_i == SelRsvd) begin
      host_err = 1'b1;
    end else if (host_sel_i != SelChT) begin
      host_err = ({20'd0, host_addr_i} >= CELLS);
    end
  end

`ifdef VGACHARGEN_MEM_ARB_FILL_EN

  localparam logic [11:0] LastCell = 12'(CELLS - 1);

  typedef enum logic {StIdle, StFill} state_e;

  state_e               state_q, state_d;
  logic [11:0]          cnt_q, cnt_d;
  logic [CH_MAP_DW-1:0] char_q, char_d;
  logic [COL_DW-1:0]    col_q, col_d;
  logic                 last_fill_q, last_fill_d;  // 1: fill was granted last
  logic                 fill_req;
  logic                 done;

  assign fill_req = (state_q == StFill);

  // Round robin: on contention the requester not granted last wins. The host
  // is held off while reset is asserted so no write escapes during reset.
  assign host_gnt = arstn_i & host_valid_i & (~fill_req | last_fill_q);
  assign fill_gnt = fill_req & ~(host_valid_i & last_fill_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    char_d      = char_q;
    col_d       = col_q;
    last_fill_d = last_fill_q;
    done        = 1'b0;

    if (host_gnt) begin
      last_fill_d = 1'b0;
    end else if (fill_gnt) begin
      last_fill_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (fill_start_i) begin
          state_d = StFill;
          cnt_d   = '0;
          char_d  = fill_char_i;
          col_d   = fill_col_i;
        end
      end
      StFill: begin
        if (fill_gnt) begin
          if (cnt_q == LastCell) begin
            state_d = StIdle;
            cnt_d   = '0;
            done    = 1'b1;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      char_q      <= '0;
      col_q       <= '0;
      last_fill_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      char_q      <= char_d;
      col_q       <= col_d;
      last_fill_q <= last_fill_d;
    end
  end

  assign fill_cnt    = cnt_q;
  assign fill_char   = char_q;
  assign fill_col    = col_q;
  assign fill_busy_o = fill_req;
  assign fill_done_o = done;

`else

  logic unused_fill;
  assign unused_fill = ^{fill_start_i, fill_char_i, fill_col_i};

  assign host_gnt    = arstn_i & host_valid_i;
  assign fill_gnt    = 1'b0;
  assign fill_cnt    = '0;
  assign fill_char   = '0;
  assign fill_col    = '0;
  assign fill_busy_o = 1'b0;
  assign fill_done_o = 1'b0;

`endif

  assign host_ready_o = host_gnt;

  // Port A steering: the fill owns both maps in its grant cycles.
  always_comb begin
    ch_map_addr_o  = fill_gnt ? fill_cnt : host_addr_i;
    ch_map_data_o  = fill_gnt ? fill_char : host_wdata_i[CH_MAP_DW-1:0];
    ch_map_wen_o   = fill_gnt |
                     (host_gnt & host_we_i & ~host_err & (host_sel_i == SelChMap));
    col_map_addr_o = fill_gnt ? fill_cnt : host_addr_i;
    col_map_data_o = fill_gnt ? fill_col : host_wdata_i[COL_DW-1:0];
    col_map_wen_o  = fill_gnt |
                     (host_gnt & host_we_i & ~host_err & (host_sel_i == SelColMap));
    ch_t_rw_addr_o = host_addr_i[CH_T_AW-1:0];
    ch_t_rw_data_o = host_wdata_i;
    ch_t_rw_wen_o  = host_gnt & host_we_i & (host_sel_i == SelChT);
  end

  // Response stage lines up with the one-cycle BRAM read latency.
  logic       rsp_valid_q;
  logic       rsp_err_q;
  logic       rsp_rd_q;
  logic [1:0] rsp_sel_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
      rsp_sel_q   <= '0;
    end else begin
      rsp_valid_q <= host_gnt;
      rsp_err_q   <= host_gnt & host_err;
      rsp_rd_q    <= host_gnt & ~host_we_i & ~host_err;
      rsp_sel_q   <= host_sel_i;
    end
  end

  always_comb begin
    rsp_rdata_o = '0;
    if (rsp_valid_q && rsp_rd_q) begin
      unique case (rsp_sel_q)
        SelChMap:  rsp_rdata_o[CH_MAP_DW-1:0] = ch_map_rdata_i;
        SelColMap: rsp_rdata_o[COL_DW-1:0]    = col_map_rdata_i;
        SelChT:    rsp_rdata_o                = ch_t_rw_rdata_i;
        default:   rsp_rdata_o                = '0;
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_vgachargen_mem_arb.sv
// Directed self-checking bench for vgachargen_mem_arb: host writes/reads,
// error decoding, and (when VGACHARGEN_MEM_ARB_FILL_EN is defined) the fill
// engine, round-robin sharing and reset abort.
module tb_vgachargen_mem_arb;

  localparam int CELLS = 2400;

  logic         clk_i = 1'b0;
  logic         arstn_i;
  logic         host_valid_i;
  logic         host_ready_o;
  logic         host_we_i;
  logic [1:0]   host_sel_i;
  logic [11:0]  host_addr_i;
  logic [127:0] host_wdata_i;
  logic         rsp_valid_o;
  logic         rsp_err_o;
  logic [127:0] rsp_rdata_o;
  logic         fill_start_i;
  logic [8:0]   fill_char_i;
  logic [7:0]   fill_col_i;
  logic         fill_busy_o;
  logic         fill_done_o;
  logic [11:0]  ch_map_addr_o;
  logic [8:0]   ch_map_data_o;
  logic         ch_map_wen_o;
  logic [8:0]   ch_map_rdata_i;
  logic [11:0]  col_map_addr_o;
  logic [7:0]   col_map_data_o;
  logic         col_map_wen_o;
  logic [7:0]   col_map_rdata_i;
  logic [7:0]   ch_t_rw_addr_o;
  logic [127:0] ch_t_rw_data_o;
  logic         ch_t_rw_wen_o;
  logic [127:0] ch_t_rw_rdata_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  vgachargen_mem_arb dut (
    .clk_i           (clk_i),
    .arstn_i         (arstn_i),
    .host_valid_i    (host_valid_i),
    .host_ready_o    (host_ready_o),
    .host_we_i       (host_we_i),
    .host_sel_i      (host_sel_i),
    .host_addr_i     (host_addr_i),
    .host_wdata_i    (host_wdata_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_err_o       (rsp_err_o),
    .rsp_rdata_o     (rsp_rdata_o),
    .fill_start_i    (fill_start_i),
    .fill_char_i     (fill_char_i),
    .fill_col_i      (fill_col_i),
    .fill_busy_o     (fill_busy_o),
    .fill_done_o     (fill_done_o),
    .ch_map_addr_o   (ch_map_addr_o),
    .ch_map_data_o   (ch_map_data_o),
    .ch_map_wen_o    (ch_map_wen_o),
    .ch_map_rdata_i  (ch_map_rdata_i),
    .col_map_addr_o  (col_map_addr_o),
    .col_map_data_o  (col_map_data_o),
    .col_map_wen_o   (col_map_wen_o),
    .col_map_rdata_i (col_map_rdata_i),
    .ch_t_rw_addr_o  (ch_t_rw_addr_o),
    .ch_t_rw_data_o  (ch_t_rw_data_o),
    .ch_t_rw_wen_o   (ch_t_rw_wen_o),
    .ch_t_rw_rdata_i (ch_t_rw_rdata_i)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a host request just after a rising edge; outputs settle by +1.
  task automatic host_req(input logic we, input logic [1:0] sel, input logic [11:0] addr,
                          input logic [127:0] wdata);
    @(posedge clk_i);
    #1;
    host_valid_i = 1'b1;
    host_we_i    = we;
    host_sel_i   = sel;
    host_addr_i  = addr;
    host_wdata_i = wdata;
    #1;
  endtask

  // Next cycle with host idle, sampling the response.
  task automatic host_idle();
    @(posedge clk_i);
    #1;
    host_valid_i = 1'b0;
    #1;
  endtask

  // Run one fill and tally what was observed. With host_load the host holds a
  // ch_t_rw read request every cycle; abort_at >= 0 pulls reset right after
  // that cell is written.
  task automatic run_fill(input logic [8:0] ch, input logic [7:0] co, input bit host_load,
                          input int abort_at, output int busy_n, output int done_n,
                          output int bad);
    int  fidx;
    bit  host_turn;
    busy_n = 0;
    done_n = 0;
    bad    = 0;
    fidx   = 0;
    @(posedge clk_i);
    #1;
    fill_start_i = 1'b1;
    fill_char_i  = ch;
    fill_col_i   = co;
    @(posedge clk_i);
    #1;
    fill_start_i = 1'b0;
    fill_char_i  = 9'h1AA;  // must have been latched already
    fill_col_i   = 8'h55;
    for (int k = 0; k < 6000; k++) begin
      if (host_load) begin
        host_valid_i = 1'b1;
        host_we_i    = 1'b0;
        host_sel_i   = 2'd2;
        host_addr_i  = 12'(k);
      end
      fill_start_i = (k == 100);  // restart attempt mid-fill must be ignored
      #1;
      if (!fill_busy_o) break;
      busy_n++;
      if (fill_done_o) done_n++;
      host_turn = host_load && (k % 2 == 0);
      if (host_turn) begin
        if (!host_ready_o || ch_map_wen_o || col_map_wen_o || fill_done_o) bad++;
      end else begin
        if (host_ready_o) bad++;
        if (!ch_map_wen_o || !col_map_wen_o) bad++;
        if (ch_map_addr_o != 12'(fidx) || col_map_addr_o != 12'(fidx)) bad++;
        if (ch_map_data_o != ch || col_map_data_o != co) bad++;
        if (fill_done_o != (fidx == CELLS - 1)) bad++;
        fidx++;
        if (abort_at >= 0 && fidx == abort_at + 1) begin
          arstn_i = 1'b0;
          #1;
          if (ch_map_wen_o || col_map_wen_o || ch_t_rw_wen_o) bad++;
          if (fill_busy_o || fill_done_o) bad++;
          break;
        end
      end
      @(posedge clk_i);
      #1;
    end
    host_valid_i = 1'b0;
    fill_start_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n, done_n, bad;
    arstn_i         = 1'b0;
    host_valid_i    = 1'b1;   // request during reset must not write
    host_we_i       = 1'b1;
    host_sel_i      = 2'd0;
    host_addr_i     = 12'd5;
    host_wdata_i    = 128'h1;
    fill_start_i    = 1'b0;
    fill_char_i     = '0;
    fill_col_i      = '0;
    ch_map_rdata_i  = '0;
    col_map_rdata_i = '0;
    ch_t_rw_rdata_i = '0;

    #3;
    chk("rst_ch_map_wen", ch_map_wen_o, 0);
    chk("rst_ready", host_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_busy", fill_busy_o, 0);
    chk("rst_done", fill_done_o, 0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_rsp_valid_held", rsp_valid_o, 0);
    host_valid_i = 1'b0;
    arstn_i      = 1'b1;

    // col_map write, addr 5, data 0xA3
    host_req(1'b1, 2'd1, 12'd5, 128'hA3);
    chk("wr_col_ready", host_ready_o, 1);
    chk("wr_col_wen", col_map_wen_o, 1);
    chk("wr_col_addr", col_map_addr_o, 5);
    chk("wr_col_data", col_map_data_o, 8'hA3);
    chk("wr_col_other_wen", {ch_map_wen_o, ch_t_rw_wen_o}, 0);
    host_idle();
    chk("wr_col_wen_drop", col_map_wen_o, 0);
    chk("wr_col_rsp_valid", rsp_valid_o, 1);
    chk("wr_col_rsp_err", rsp_err_o, 0);

    // ch_t_rw read, addr 0x41
    host_req(1'b0, 2'd2, 12'h041, 128'h0);
    chk("rd_cht_addr", ch_t_rw_addr_o, 8'h41);
    chk("rd_cht_wen", ch_t_rw_wen_o, 0);
    chk("rd_cht_ready", host_ready_o, 1);
    ch_t_rw_rdata_i = 128'h1234;
    host_idle();
    chk("rd_cht_rsp_valid", rsp_valid_o, 1);
    chk("rd_cht_rdata", rsp_rdata_o, 128'h1234);
    chk("rd_cht_err", rsp_err_o, 0);

    // out-of-range map read and reserved target
    ch_map_rdata_i = 9'h1FF;
    host_req(1'b0, 2'd0, 12'd2400, 128'h0);
    chk("err_rd_wen", {ch_map_wen_o, col_map_wen_o, ch_t_rw_wen_o}, 0);
    host_idle();
    chk("err_rd_valid", rsp_valid_o, 1);
    chk("err_rd_err", rsp_err_o, 1);
    chk("err_rd_rdata", rsp_rdata_o, 0);
    host_req(1'b1, 2'd3, 12'd7, 128'hFF);
    chk("err_sel3_wen", {ch_map_wen_o, col_map_wen_o, ch_t_rw_wen_o}, 0);
    host_idle();
    chk("err_sel3_err", rsp_err_o, 1);
    chk("err_sel3_rdata", rsp_rdata_o, 0);
    host_req(1'b1, 2'd1, 12'd2400, 128'h77);
    chk("err_wr_col_wen", col_map_wen_o, 0);
    host_idle();
    chk("err_wr_col_err", {rsp_valid_o, rsp_err_o}, 2'b11);

    // last valid cell is accepted
    host_req(1'b1, 2'd0, 12'd2399, 128'h1FF);
    chk("wr_last_wen", ch_map_wen_o, 1);
    chk("wr_last_addr", ch_map_addr_o, 12'd2399);
    chk("wr_last_data", ch_map_data_o, 9'h1FF);
    host_idle();
    chk("wr_last_err", {rsp_valid_o, rsp_err_o}, 2'b10);

    // col_map read is zero-extended and muxed from the right memory
    col_map_rdata_i = 8'hC5;
    host_req(1'b0, 2'd1, 12'd7, 128'h0);
    host_idle();
    chk("rd_col_rdata", rsp_rdata_o, 128'hC5);

    // ch_t_rw ignores upper address bits and never errors
    host_req(1'b1, 2'd2, 12'hF41, {4{32'hDEADBEEF}});
    chk("wr_cht_wen", ch_t_rw_wen_o, 1);
    chk("wr_cht_addr", ch_t_rw_addr_o, 8'h41);
    chk("wr_cht_data", ch_t_rw_data_o, {4{32'hDEADBEEF}});
    host_idle();
    chk("wr_cht_err", {rsp_valid_o, rsp_err_o}, 2'b10);
    @(posedge clk_i);
    #2;
    chk("idle_rsp_valid", rsp_valid_o, 0);

`ifdef VGACHARGEN_MEM_ARB_FILL_EN
    // plain fill
    run_fill(9'h020, 8'h0F, 1'b0, -1, busy_n, done_n, bad);
    chk("fill_busy_cycles", 128'(busy_n), 128'(CELLS));
    chk("fill_done_count", 128'(done_n), 1);
    chk("fill_seq_bad", 128'(bad), 0);

    // fill shared with a continuously requesting host
    run_fill(9'h041, 8'h3C, 1'b1, -1, busy_n, done_n, bad);
    chk("share_busy_cycles", 128'(busy_n), 128'(2 * CELLS));
    chk("share_done_count", 128'(done_n), 1);
    chk("share_seq_bad", 128'(bad), 0);

    // reset at cell 1000 aborts, then a fresh fill starts from 0
    run_fill(9'h100, 8'hA5, 1'b0, 1000, busy_n, done_n, bad);
    chk("abort_busy_cycles", 128'(busy_n), 1001);
    chk("abort_done_count", 128'(done_n), 0);
    chk("abort_seq_bad", 128'(bad), 0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("abort_rst_done", fill_done_o, 0);
    arstn_i = 1'b1;
    #1;
    chk("abort_idle_busy", fill_busy_o, 0);
    run_fill(9'h020, 8'h0F, 1'b0, -1, busy_n, done_n, bad);
    chk("restart_busy_cycles", 128'(busy_n), 128'(CELLS));
    chk("restart_done_count", 128'(done_n), 1);
    chk("restart_seq_bad", 128'(bad), 0);
`else
    // fill disabled: start request has no effect
    @(posedge clk_i);
    #1;
    fill_start_i = 1'b1;
    fill_char_i  = 9'h020;
    fill_col_i   = 8'h0F;
    #1;
    chk("nofill_start_wen", {ch_map_wen_o, col_map_wen_o}, 0);
    @(posedge clk_i);
    #1;
    fill_start_i = 1'b0;
    #1;
    chk("nofill_busy", fill_busy_o, 0);
    chk("nofill_done", fill_done_o, 0);
    chk("nofill_wen", {ch_map_wen_o, col_map_wen_o}, 0);
    host_req(1'b1, 2'd0, 12'd3, 128'h020);
    chk("nofill_host_ready", host_ready_o, 1);
    chk("nofill_host_wen", ch_map_wen_o, 1);
    host_idle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
